// File: rtl/encrypt_v3_pkg.sv
// PRESENT-80 constants and round helper functions shared by the round and top modules.
package encrypt_v3_pkg;

  localparam int B      = 64;
  localparam int KW     = 80;
  localparam int ROUNDS = 31;

  // S-box packed as 16 nibbles, entry n at bits [4n+3:4n]
  localparam logic [63:0] SBOX_TABLE = 64'h2174_8FE3_DA09_B65C;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    logic [5:0] idx;
    idx = {x, 2'b00};
    return SBOX_TABLE[idx +: 4];
  endfunction

  function automatic logic [B-1:0] sbox_layer(input logic [B-1:0] x);
    logic [B-1:0] r;
    r = '0;
    for (int n = 0; n < B / 4; n++) begin
      r[4*n +: 4] = sbox4(x[4*n +: 4]);
    end
    return r;
  endfunction

  // Bit j moves to bit 16*j mod 63; bit 63 is a fixed point.
  function automatic logic [B-1:0] p_layer(input logic [B-1:0] x);
    logic [B-1:0] r;
    r = '0;
    for (int j = 0; j < B - 1; j++) begin
      r[(16 * j) % 63] = x[j];
    end
    r[B-1] = x[B-1];
    return r;
  endfunction

  function automatic logic [KW-1:0] key_update(input logic [KW-1:0] kr, input logic [4:0] rnd);
    logic [KW-1:0] r;
    r          = {kr[18:0], kr[79:19]};
    r[79:76]   = sbox4(r[79:76]);
    r[19:15]   = r[19:15] ^ rnd;
    return r;
  endfunction

endpackage

// File: rtl/encrypt_v3_round.sv
// One combinational PRESENT-80 round: add round key, S-box layer, P-layer, key schedule step.
module encrypt_v3_round
  import encrypt_v3_pkg::*;
(
  input  logic [B-1:0]  s_i,
  input  logic [KW-1:0] kr_i,
  input  logic [4:0]    rnd_i,
  output logic [B-1:0]  s_o,
  output logic [KW-1:0] kr_o
);

  logic [B-1:0] keyed;

  assign keyed = s_i ^ kr_i[KW-1:KW-B];
  assign s_o   = p_layer(sbox_layer(keyed));
  assign kr_o  = key_update(kr_i, rnd_i);

endmodule

// File: rtl/encrypt_v3.sv
// Fully pipelined PRESENT-80 encryptor: 31 registered round stages plus a whitened output register.
// Optional ENCRYPT_V3_VALID_EN adds vin/vout and a valid bit that travels with each slot.
module encrypt_v3
  import encrypt_v3_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [KW-1:0] K,
  input  logic [B-1:0]  M,
  output logic [B-1:0]  C
`ifdef ENCRYPT_V3_VALID_EN
  ,
  input  logic          vin,
  output logic          vout
`endif
);

  // live_q marks slots sampled since the last reset so stale stages never reach C
  logic [ROUNDS-1:0] live_q;
  logic [B-1:0]      c_q;
  logic [B-1:0]      c_d;

  for (genvar gi = 0; gi < ROUNDS; gi++) begin : g_stage
    localparam logic [4:0] RND = 5'(gi + 1);

    logic [B-1:0]  s_in;
    logic [KW-1:0] kr_in;
    logic [B-1:0]  s_d;
    logic [KW-1:0] kr_d;
    logic [B-1:0]  s_q;
    logic [KW-1:0] kr_q;

    if (gi == 0) begin : g_first
      assign s_in  = M;
      assign kr_in = K;
    end else begin : g_rest
      assign s_in  = g_stage[gi-1].s_q;
      assign kr_in = g_stage[gi-1].kr_q;
    end

    encrypt_v3_round u_round (
      .s_i   (s_in),
      .kr_i  (kr_in),
      .rnd_i (RND),
      .s_o   (s_d),
      .kr_o  (kr_d)
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        s_q  <= '0;
        kr_q <= '0;
      end else begin
        s_q  <= s_d;
        kr_q <= kr_d;
      end
    end
  end

  // Final whitening uses round key 32, carried by the last stage
  assign c_d = live_q[ROUNDS-1]
             ? (g_stage[ROUNDS-1].s_q ^ g_stage[ROUNDS-1].kr_q[KW-1:KW-B])
             : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      live_q <= '0;
      c_q    <= '0;
    end else begin
      live_q <= {live_q[ROUNDS-2:0], 1'b1};
      c_q    <= c_d;
    end
  end

  assign C = c_q;

`ifdef ENCRYPT_V3_VALID_EN
  logic [ROUNDS-1:0] valid_q;
  logic              vout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      vout_q  <= 1'b0;
    end else begin
      valid_q <= {valid_q[ROUNDS-2:0], vin};
      vout_q  <= valid_q[ROUNDS-1];
    end
  end

  assign vout = vout_q;
`endif

endmodule

// File: tb/tb_encrypt_v3.sv
// Directed bench for encrypt_v3: reference vectors, back-to-back streaming, latency edges, mid-stream reset.
module tb_encrypt_v3;

  logic        clk = 1'b0;
  logic        rst;
  logic [79:0] K;
  logic [63:0] M;
  logic [63:0] C;
  logic        vin;
  logic        vout;

  int checks   = 0;
  int failures = 0;

  logic [79:0] kv [4];
  logic [63:0] mv [4];
  logic [63:0] cv [4];

  always #5 clk = ~clk;

  encrypt_v3 dut (
    .clk (clk),
    .rst (rst),
    .K   (K),
    .M   (M),
    .C   (C)
`ifdef ENCRYPT_V3_VALID_EN
    ,
    .vin (vin),
    .vout(vout)
`endif
  );

`ifndef ENCRYPT_V3_VALID_EN
  assign vout = 1'b0;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_vout(input string tag, input logic exp);
`ifdef ENCRYPT_V3_VALID_EN
    chk(tag, {63'd0, vout}, {63'd0, exp});
`else
    if (exp === 1'bx) $display("unused %s", tag);
`endif
  endtask

  initial begin
    logic [63:0] exp_c;
    logic        exp_v;

    kv[0] = 80'h0;                    mv[0] = 64'h0;
    kv[1] = 80'hFFFF_FFFF_FFFF_FFFF_FFFF; mv[1] = 64'h0;
    kv[2] = 80'h0;                    mv[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    kv[3] = 80'hFFFF_FFFF_FFFF_FFFF_FFFF; mv[3] = 64'hFFFF_FFFF_FFFF_FFFF;
    cv[0] = 64'h5579_C138_7B22_8445;
    cv[1] = 64'hE72C_46C0_F594_5049;
    cv[2] = 64'hA112_FFC7_2F68_417B;
    cv[3] = 64'h3333_DCD3_2132_10D2;

    rst = 1'b1; K = '0; M = '0; vin = 1'b1;
    step();
    step();
    chk("reset_C", C, 64'h0);
    chk_vout("reset_vout", 1'b0);

    // Stream all four vectors back-to-back, then idle slots of K=0/M=0 with vin low.
    rst = 1'b0;
    for (int t = 0; t < 37; t++) begin
      if (t < 4) begin
        K = kv[t]; M = mv[t]; vin = 1'b1;
      end else begin
        K = '0; M = '0; vin = 1'b0;
      end
      step();
      if (t < 31)      exp_c = 64'h0;
      else if (t < 35) exp_c = cv[t-31];
      else             exp_c = cv[0];
      exp_v = (t >= 31) && (t < 35);
      chk($sformatf("stream_C_t%0d", t), C, exp_c);
      chk_vout($sformatf("stream_vout_t%0d", t), exp_v);
      if (t >= 31 && t < 35)
        $display("stream result %0d: C=%h vout=%b", t - 31, C, vout);
    end

    // Fill the pipe with vector 1, then reset for one edge mid-stream.
    for (int t = 0; t < 10; t++) begin
      K = kv[1]; M = mv[1]; vin = 1'b1;
      step();
    end
    rst = 1'b1;
    step();
    chk("midrst_C", C, 64'h0);
    chk_vout("midrst_vout", 1'b0);

    rst = 1'b0;
    for (int t = 0; t < 32; t++) begin
      K = kv[3]; M = mv[3]; vin = 1'b1;
      step();
      exp_c = (t < 31) ? 64'h0 : cv[3];
      exp_v = (t >= 31);
      chk($sformatf("postrst_C_t%0d", t), C, exp_c);
      chk_vout($sformatf("postrst_vout_t%0d", t), exp_v);
    end
    $display("post-reset result: C=%h vout=%b", C, vout);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
